// File: rtl/mole_round_scorer_pkg.sv
// Shared definitions for the whack-a-mole round engine: state encodings,
// result codes and the LFSR seed/tap mask used by the board and keypad blocks.
package mole_round_scorer_pkg;

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_SPAWN = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HIT   = 3'd3,
    ST_MISS  = 3'd4,
    ST_OVER  = 3'd5
  } state_e;

  localparam logic [1:0] ADD_MISS = 2'd0;
  localparam logic [1:0] ADD_HIT  = 2'd1;
  localparam logic [1:0] ADD_IDLE = 2'd2;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form taps bits 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mole_round_scorer_lfsr.sv
// 8-bit Fibonacci LFSR with run enable; resets to the shared seed and
// exposes its low OUT_W bits as the random hole source.
module mole_round_scorer_lfsr
  import mole_round_scorer_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic             systemClock,
  input  logic             reset,
  input  logic             enable,
  output logic [OUT_W-1:0] value
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (enable) lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge systemClock or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_d;
  end

  assign value = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/mole_round_scorer.sv
// Whack-a-mole round engine: random hole pick, timed hit window, key judging,
// saturating score/streak, difficulty pacing via window shrink, and game end.
//
//  state | meaning
//  OFF   | idle, game switch off; score/streak held
//  SPAWN | pick next hole, load window counter
//  WAIT  | mole shown, waiting for key or window expiry
//  HIT   | one-cycle hit result
//  MISS  | one-cycle miss result, shrink/game-over decision
//  OVER  | game finished until switch goes low
module mole_round_scorer
  import mole_round_scorer_pkg::*;
#(
  parameter int N_HOLES       = 8,
  parameter int SCORE_W       = 10,
  parameter int WINDOW_CYCLES = 1024,
  parameter int WINDOW_STEP   = 64,
  parameter int WINDOW_MIN    = 128,
  parameter int BONUS_STREAK  = 4,
  parameter int SHRINK_MISSES = 3,
  parameter int MAX_MISSES    = 8,
  localparam int IDX_W        = $clog2(N_HOLES)
) (
  input  logic               systemClock,
  input  logic               reset,
  input  logic               enable,
  input  logic               key_valid,
  input  logic [IDX_W-1:0]   key_idx,
  output logic               mole_valid,
  output logic [IDX_W-1:0]   mole_idx,
  output logic [1:0]         add,
  output logic               shrink,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         streak,
  output logic               game_over,
  output logic [2:0]         state
);

  localparam int CNT_W  = $clog2(WINDOW_CYCLES + 1);
  localparam int CONS_W = $clog2(SHRINK_MISSES + 1);
  localparam int MISS_W = $clog2(MAX_MISSES + 1);

  localparam logic [IDX_W:0]   N_EXT    = (IDX_W+1)'(N_HOLES);
  localparam logic [IDX_W-1:0] N_IDX    = IDX_W'(N_HOLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_HOLES - 1);
  localparam logic [CNT_W-1:0] WIN_INIT = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] WIN_STEP = CNT_W'(WINDOW_STEP);
  localparam logic [CNT_W-1:0] WIN_MIN  = CNT_W'(WINDOW_MIN);
  localparam logic [CNT_W-1:0] WIN_KNEE = CNT_W'(WINDOW_MIN + WINDOW_STEP);
  localparam logic [3:0]       BONUS_C  = 4'(BONUS_STREAK);
  localparam logic [CONS_W-1:0] SHRINK_C = CONS_W'(SHRINK_MISSES);
  localparam logic [MISS_W-1:0] MAX_C    = MISS_W'(MAX_MISSES);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    mole_idx_q, mole_idx_d;
  logic                mole_valid_q, mole_valid_d;
  logic [1:0]          add_q, add_d;
  logic                shrink_q, shrink_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [3:0]          streak_q, streak_d;
  logic                game_over_q, game_over_d;
  logic [CNT_W-1:0]    counter_q, counter_d;
  logic [CNT_W-1:0]    reload_q, reload_d;
  logic [CONS_W-1:0]   consec_q, consec_d;
  logic [MISS_W-1:0]   miss_total_q, miss_total_d;

  logic [IDX_W-1:0]    lfsr_bits;
  logic [IDX_W-1:0]    spawn_mod;
  logic [IDX_W-1:0]    spawn_idx;
  logic [SCORE_W:0]    score_sum;
  logic [CONS_W-1:0]   consec_next;
  logic                do_hit;
  logic                do_miss;

  mole_round_scorer_lfsr #(.OUT_W(IDX_W)) u_lfsr (
    .systemClock (systemClock),
    .reset       (reset),
    .enable      (enable),
    .value       (lfsr_bits)
  );

  // One conditional subtract suffices because N_HOLES > 2^(IDX_W-1).
  always_comb begin
    spawn_mod = lfsr_bits;
    if ({1'b0, lfsr_bits} >= N_EXT) spawn_mod = lfsr_bits - N_IDX;
    spawn_idx = spawn_mod;
    if (spawn_mod == mole_idx_q) spawn_idx = (spawn_mod == LAST_IDX) ? '0 : spawn_mod + 1'b1;
  end

  always_comb begin
    score_sum   = {1'b0, score_q} +
                  ((streak_q >= BONUS_C) ? (SCORE_W+1)'(2) : (SCORE_W+1)'(1));
    consec_next = consec_q + 1'b1;
  end

  always_comb begin
    state_d      = state_q;
    mole_idx_d   = mole_idx_q;
    counter_d    = counter_q;
    reload_d     = reload_q;
    score_d      = score_q;
    streak_d     = streak_q;
    consec_d     = consec_q;
    miss_total_d = miss_total_q;
    shrink_d     = 1'b0;
    do_hit       = 1'b0;
    do_miss      = 1'b0;

    if (!enable) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d      = ST_SPAWN;
          score_d      = '0;
          streak_d     = '0;
          consec_d     = '0;
          miss_total_d = '0;
          reload_d     = WIN_INIT;
        end
        ST_SPAWN: begin
          mole_idx_d = spawn_idx;
          counter_d  = reload_q;
          state_d    = ST_WAIT;
        end
        ST_WAIT: begin
          // A key press wins over window expiry in the same cycle.
          if (key_valid) begin
            if (key_idx == mole_idx_q) do_hit  = 1'b1;
            else                       do_miss = 1'b1;
          end else if (counter_q == '0) begin
            do_miss = 1'b1;
          end else begin
            counter_d = counter_q - 1'b1;
          end
        end
        ST_HIT:  state_d = ST_SPAWN;
        ST_MISS: state_d = (miss_total_q == MAX_C) ? ST_OVER : ST_SPAWN;
        ST_OVER: state_d = ST_OVER;
        default: state_d = ST_OFF;
      endcase
    end

    // Results land on the edge into HIT/MISS so they are valid during that state.
    if (do_hit) begin
      state_d  = ST_HIT;
      score_d  = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
      streak_d = (streak_q == 4'hF) ? 4'hF : streak_q + 1'b1;
      consec_d = '0;
      reload_d = (reload_q >= WIN_KNEE) ? reload_q - WIN_STEP : WIN_MIN;
    end
    if (do_miss) begin
      state_d      = ST_MISS;
      streak_d     = '0;
      miss_total_d = miss_total_q + 1'b1;
      if (consec_next == SHRINK_C) begin
        shrink_d = 1'b1;
        consec_d = '0;
      end else begin
        consec_d = consec_next;
      end
    end

    add_d        = (state_d == ST_HIT)  ? ADD_HIT :
                   (state_d == ST_MISS) ? ADD_MISS : ADD_IDLE;
    mole_valid_d = (state_d == ST_WAIT);
    game_over_d  = (state_d == ST_OVER);
  end

  always_ff @(posedge systemClock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_OFF;
      mole_idx_q   <= '0;
      mole_valid_q <= 1'b0;
      add_q        <= ADD_IDLE;
      shrink_q     <= 1'b0;
      score_q      <= '0;
      streak_q     <= '0;
      game_over_q  <= 1'b0;
      counter_q    <= '0;
      reload_q     <= WIN_INIT;
      consec_q     <= '0;
      miss_total_q <= '0;
    end else begin
      state_q      <= state_d;
      mole_idx_q   <= mole_idx_d;
      mole_valid_q <= mole_valid_d;
      add_q        <= add_d;
      shrink_q     <= shrink_d;
      score_q      <= score_d;
      streak_q     <= streak_d;
      game_over_q  <= game_over_d;
      counter_q    <= counter_d;
      reload_q     <= reload_d;
      consec_q     <= consec_d;
      miss_total_q <= miss_total_d;
    end
  end

  assign mole_valid = mole_valid_q;
  assign mole_idx   = mole_idx_q;
  assign add        = add_q;
  assign shrink     = shrink_q;
  assign score      = score_q;
  assign streak     = streak_q;
  assign game_over  = game_over_q;
  assign state      = state_q;

endmodule

// File: tb/tb_mole_round_scorer.sv
// Directed bench for mole_round_scorer with 5 holes, 16-cycle window and
// 4-bit score; hole picks are checked against an independent LFSR model.
module tb_mole_round_scorer;

  localparam logic [2:0] S_OFF = 3'd0, S_SPAWN = 3'd1, S_WAIT = 3'd2,
                         S_HIT = 3'd3, S_MISS = 3'd4, S_OVER = 3'd5;

  logic       systemClock = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       key_valid = 1'b0;
  logic [2:0] key_idx = 3'd0;
  logic       mole_valid;
  logic [2:0] mole_idx;
  logic [1:0] add;
  logic       shrink;
  logic [3:0] score;
  logic [3:0] streak;
  logic       game_over;
  logic [2:0] state;

  int errors = 0;
  int checks = 0;

  mole_round_scorer #(
    .N_HOLES(5), .SCORE_W(4), .WINDOW_CYCLES(16), .WINDOW_STEP(4), .WINDOW_MIN(8),
    .BONUS_STREAK(4), .SHRINK_MISSES(3), .MAX_MISSES(8)
  ) dut (
    .systemClock(systemClock), .reset(reset), .enable(enable),
    .key_valid(key_valid), .key_idx(key_idx),
    .mole_valid(mole_valid), .mole_idx(mole_idx), .add(add), .shrink(shrink),
    .score(score), .streak(streak), .game_over(game_over), .state(state)
  );

  always #5 systemClock = ~systemClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge systemClock);
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    int n = 0;
    while (state !== s && n < budget) begin
      tick();
      n++;
    end
    chk(tag, state, s);
  endtask

  task automatic press(input logic [2:0] k);
    key_valid = 1'b1;
    key_idx   = k;
    tick();
    key_valid = 1'b0;
  endtask

  // Independent hole-pick model: LFSR x^8+x^6+x^5+x^4+1, mod 5, no repeats.
  logic [7:0] m_lfsr;
  logic [2:0] m_prev, m_pend, m_raw;
  bit         m_has_pend;

  always @(posedge systemClock or posedge reset) begin
    if (reset)       m_lfsr = 8'hA5;
    else if (enable) m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  always @(negedge systemClock) begin
    if (reset) begin
      m_prev     = 3'd0;
      m_has_pend = 1'b0;
    end else begin
      if (m_has_pend && state === S_WAIT) begin
        chk("mole_idx_model", mole_idx, m_pend);
        m_prev = m_pend;
      end
      m_has_pend = 1'b0;
      if (state === S_SPAWN) begin
        m_raw = m_lfsr[2:0];
        if (m_raw >= 3'd5) m_raw = m_raw - 3'd5;
        if (m_raw == m_prev) m_raw = (m_raw == 3'd4) ? 3'd0 : m_raw + 3'd1;
        m_pend     = m_raw;
        m_has_pend = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

  int         exp_score [11] = '{1, 2, 3, 4, 6, 8, 10, 12, 14, 15, 15};
  int         exp_reload[11] = '{12, 8, 8, 8, 8, 8, 8, 8, 8, 8, 8};
  logic [2:0] first_mole;
  int         wait_len;

  initial begin
    // reset values
    repeat (3) tick();
    chk("rst_state", state, S_OFF);
    chk("rst_add", add, 2'd2);
    chk("rst_mole_valid", mole_valid, 1'b0);
    chk("rst_mole_idx", mole_idx, 3'd0);
    chk("rst_score", score, 4'd0);
    chk("rst_streak", streak, 4'd0);
    chk("rst_shrink", shrink, 1'b0);
    chk("rst_game_over", game_over, 1'b0);
    reset = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    chk("spawn_after_enable", state, S_SPAWN);
    wait_state(S_WAIT, 5, "first_wait");
    first_mole = mole_idx;

    // hits 1..11: bonus from streak 4, saturation at 15, window shrink to floor
    for (int i = 0; i < 11; i++) begin
      wait_state(S_WAIT, 10, "hit_wait");
      press(mole_idx);
      chk("hit_state", state, S_HIT);
      chk("hit_add", add, 2'd1);
      chk("hit_score", score, exp_score[i]);
      chk("hit_streak", streak, i + 1);
      chk("hit_reload", dut.reload_q, exp_reload[i]);
      if (i == 0) begin
        chk("hit_mole_valid_low", mole_valid, 1'b0);
        tick();
        tick();
        chk("latency_mole_valid", mole_valid, 1'b1);
      end
    end

    // wrong key, then out-of-range key
    wait_state(S_WAIT, 10, "wrong_wait");
    press((mole_idx == 3'd4) ? 3'd0 : mole_idx + 3'd1);
    chk("wrong_state", state, S_MISS);
    chk("wrong_add", add, 2'd0);
    chk("wrong_streak", streak, 4'd0);
    chk("wrong_score", score, 4'd15);
    chk("wrong_shrink", shrink, 1'b0);
    wait_state(S_WAIT, 10, "oor_wait");
    press(3'd7);
    chk("oor_add", add, 2'd0);
    chk("oor_score", score, 4'd15);

    // correct key in the cycle the window counter reaches zero
    wait_state(S_WAIT, 10, "edge_wait");
    chk("edge_counter_load", dut.counter_q, 8);
    repeat (8) tick();
    chk("edge_counter_zero", dut.counter_q, 0);
    chk("edge_still_wait", state, S_WAIT);
    press(mole_idx);
    chk("edge_state", state, S_HIT);
    chk("edge_add", add, 2'd1);
    chk("edge_streak", streak, 4'd1);

    // enable low mid-WAIT holds score; re-enable clears it
    wait_state(S_WAIT, 10, "dis_wait");
    enable = 1'b0;
    tick();
    chk("dis_state", state, S_OFF);
    chk("dis_score_held", score, 4'd15);
    chk("dis_mole_valid", mole_valid, 1'b0);
    enable = 1'b1;
    tick();
    chk("reen_state", state, S_SPAWN);
    chk("reen_score", score, 4'd0);
    chk("reen_streak", streak, 4'd0);

    // eight timeouts: window runs 16 down to 0, shrink on 3rd/6th, then OVER
    for (int m = 1; m <= 8; m++) begin
      wait_state(S_WAIT, 10, "to_wait");
      wait_len = 0;
      while (state === S_WAIT && wait_len < 40) begin
        tick();
        wait_len++;
      end
      if (m == 1) chk("to_window_len", wait_len, 17);
      chk("to_state", state, S_MISS);
      chk("to_add", add, 2'd0);
      chk("to_shrink", shrink, (m == 3 || m == 6) ? 1'b1 : 1'b0);
      chk("to_game_over", game_over, 1'b0);
      if (m == 3) begin
        tick();
        chk("shrink_one_cycle", shrink, 1'b0);
      end
    end
    tick();
    chk("over_state", state, S_OVER);
    chk("over_game_over", game_over, 1'b1);
    chk("over_mole_valid", mole_valid, 1'b0);
    repeat (4) tick();
    chk("over_stays", state, S_OVER);

    // reset mid-WAIT, then identical restart
    enable = 1'b0;
    tick();
    chk("over_exit", state, S_OFF);
    enable = 1'b1;
    wait_state(S_WAIT, 10, "rst6_wait");
    repeat (3) tick();
    reset  = 1'b1;
    enable = 1'b0;
    tick();
    chk("rst6_state", state, S_OFF);
    chk("rst6_add", add, 2'd2);
    chk("rst6_mole_valid", mole_valid, 1'b0);
    chk("rst6_mole_idx", mole_idx, 3'd0);
    chk("rst6_score", score, 4'd0);
    chk("rst6_streak", streak, 4'd0);
    chk("rst6_shrink", shrink, 1'b0);
    chk("rst6_reload", dut.reload_q, 16);
    tick();
    reset = 1'b0;
    tick();
    enable = 1'b1;
    wait_state(S_WAIT, 10, "rst6_restart");
    chk("rst6_same_first_mole", mole_idx, first_mole);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
